// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain loader: serialises host words MSB-first into ccff_head for CHAIN_LEN shift cycles.
// Optional tail readback is built only when CCFF_READBACK_EN is defined.
module ccff_bitstream_loader #(
    parameter int unsigned CHAIN_LEN = 128,
    parameter int unsigned WORD_W    = 32
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              cfg_start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);

    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned IDX_W = $clog2(WORD_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [IDX_W-1:0]   r_word_idx;
    logic [WORD_W-1:0]  r_shreg;

    logic               r_in_ready;
    logic               r_shift_en;
    logic               r_busy;
    logic               r_done;

    logic               w_in_ready_nxt;
    logic               w_shift_en_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    logic               w_handshake;
    logic               w_last_bit;
    logic               w_word_end;

    assign w_handshake = in_valid & r_in_ready;
    assign w_last_bit  = (r_bit_cnt == CNT_W'(CHAIN_LEN - 1));
    assign w_word_end  = (r_word_idx == IDX_W'(WORD_W - 1));

    // State register
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; the chain-length test wins over the end-of-word test
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (cfg_start) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_handshake) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last_bit) begin
                    w_state_nxt = S_DONE;
                end else if (w_word_end) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state, so every control output comes straight off a flop
    always_comb begin
        w_in_ready_nxt = 1'b0;
        w_shift_en_nxt = 1'b0;
        w_busy_nxt     = 1'b1;
        w_done_nxt     = 1'b0;
        case (w_state_nxt)
            S_IDLE:  w_busy_nxt     = 1'b0;
            S_WAIT:  w_in_ready_nxt = 1'b1;
            S_SHIFT: w_shift_en_nxt = 1'b1;
            S_DONE:  w_done_nxt     = 1'b1;
            default: w_busy_nxt     = 1'b0;
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            r_in_ready <= 1'b0;
            r_shift_en <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_in_ready <= w_in_ready_nxt;
            r_shift_en <= w_shift_en_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Word shift register and bit/word counters
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            r_shreg    <= '0;
            r_word_idx <= '0;
            r_bit_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        r_bit_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (w_handshake) begin
                        r_shreg    <= in_data;
                        r_word_idx <= '0;
                    end
                end
                S_SHIFT: begin
                    r_shreg    <= {r_shreg[WORD_W-2:0], 1'b0};
                    r_word_idx <= r_word_idx + IDX_W'(1);
                    r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
                end
                default: begin
                    r_bit_cnt <= r_bit_cnt;
                end
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign ccff_head     = r_shreg[WORD_W-1];
    assign ccff_shift_en = r_shift_en;
    assign busy          = r_busy;
    assign done          = r_done;

`ifdef CCFF_READBACK_EN
    logic [WORD_W-1:0] r_rb_shreg;
    logic [WORD_W-1:0] r_rb_data;
    logic              r_rb_valid;
    logic [WORD_W-1:0] w_rb_word;

    assign w_rb_word = {r_rb_shreg[WORD_W-2:0], ccff_tail};

    // Tail capture on each transfer edge; a short final word is left-aligned with zero fill
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            r_rb_shreg <= '0;
            r_rb_data  <= '0;
            r_rb_valid <= 1'b0;
        end else begin
            r_rb_valid <= 1'b0;
            if (r_state == S_SHIFT) begin
                r_rb_shreg <= w_rb_word;
                if (w_word_end || w_last_bit) begin
                    r_rb_valid <= 1'b1;
                    r_rb_data  <= w_rb_word << (IDX_W'(WORD_W - 1) - r_word_idx);
                end
            end
        end
    end

    assign rb_data  = r_rb_data;
    assign rb_valid = r_rb_valid;
`else
    logic w_unused_tail;

    assign w_unused_tail = ccff_tail;
    assign rb_data       = '0;
    assign rb_valid      = 1'b0;
`endif

endmodule
